vector_sequencer: RTL

//  Command-side initiator for the X/Y position counters of the vector generator.

---
 rtl/vg_pkg.sv | 34 +++
 rtl/vg_draw_timer.sv | 34 +++
 rtl/vector_sequencer.sv | 118 +++++++++++
 3 files changed

// File: rtl/vg_pkg.sv
// Shared definitions for the vector generator: opcodes, sequencer states,
// command field layout and the rate-multiplier sweep length.
package vg_pkg;

   localparam int VG_BRM_PERIOD = 64;
   localparam int VG_LEN_W      = 12;

   localparam logic [1:0] VG_OP_NOP  = 2'b00;
   localparam logic [1:0] VG_OP_LOAD = 2'b01;
   localparam logic [1:0] VG_OP_DRAW = 2'b10;
   localparam logic [1:0] VG_OP_HALT = 2'b11;

   // cmd_data layout: [39:38] op, [37] beam_en, [36] rsvd, [35:24] x, [23:12] y, [11:0] len
   localparam int CMD_W    = 40;
   localparam int OP_HI    = 39;
   localparam int OP_LO    = 38;
   localparam int BEAM_BIT = 37;
   localparam int RSVD_BIT = 36;
   localparam int X_HI     = 35;
   localparam int X_LO     = 24;
   localparam int Y_HI     = 23;
   localparam int Y_LO     = 12;
   localparam int LEN_LO   = 0;

   typedef enum logic [2:0] {
      VG_IDLE,
      VG_LOAD,
      VG_SETUP,
      VG_DRAW,
      VG_END,
      VG_HALTED
   } vg_state_t;

endpackage

// File: rtl/vg_draw_timer.sv
// Loadable down-counter that times a DRAW; zero_o flags the final cycle.
module vg_draw_timer #(
   parameter int TIMER_W = 18
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load_i,
   input  logic               en_i,
   input  logic [TIMER_W-1:0] load_val_i,
   output logic               zero_o
);

   logic [TIMER_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (en_i && (count_q != '0)) begin
         count_d = count_q - TIMER_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/vector_sequencer.sv
// Command-side sequencer for the X/Y position counters: turns LOAD/DRAW/HALT
// commands into dv_x/dv_y, go, haltstrobe and timer0 with registered outputs.
module vector_sequencer
   import vg_pkg::*;
#(
   parameter int BRM_PERIOD = VG_BRM_PERIOD,
   parameter int LEN_W      = VG_LEN_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [CMD_W-1:0] cmd_data,
   input  logic             abort,
   input  logic             restart,
   output logic [11:0]      dv_x,
   output logic [11:0]      dv_y,
   output logic             go,
   output logic             haltstrobe,
   output logic             timer0,
   output logic             beam_on,
   output logic             busy
);

   localparam int TIMER_W = LEN_W + $clog2(BRM_PERIOD);

   vg_state_t          state_q, state_d;
   logic               cmd_ready_q, go_q, haltstrobe_q, timer0_q, beam_on_q, busy_q;
   logic [11:0]        dv_x_q, dv_y_q;
   logic               beam_en_q;
   logic [LEN_W-1:0]   len_q;
   logic [1:0]         op;
   logic               accept;
   logic               timer_zero;
   logic [TIMER_W-1:0] timer_load_val;
   logic               unused_rsvd;

   assign op          = cmd_data[OP_HI:OP_LO];
   assign accept      = cmd_valid && cmd_ready_q;
   assign unused_rsvd = cmd_data[RSVD_BIT];

   // Loaded with one less than the period count so that zero marks the last DRAW cycle.
   assign timer_load_val = TIMER_W'(len_q) * TIMER_W'(BRM_PERIOD) - TIMER_W'(1);

   vg_draw_timer #(
      .TIMER_W (TIMER_W)
   ) u_draw_timer (
      .clk        (clk),
      .reset      (reset),
      .load_i     (state_q == VG_SETUP),
      .en_i       (state_q == VG_DRAW),
      .load_val_i (timer_load_val),
      .zero_o     (timer_zero)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         VG_IDLE: begin
            if (accept) begin
               case (op)
                  VG_OP_LOAD: state_d = VG_LOAD;
                  VG_OP_DRAW: state_d = VG_SETUP;
                  VG_OP_HALT: state_d = VG_HALTED;
                  default:    state_d = VG_IDLE;
               endcase
            end
         end
         VG_LOAD:   state_d = VG_IDLE;
         VG_SETUP:  state_d = (abort || (len_q == '0)) ? VG_END : VG_DRAW;
         VG_DRAW:   state_d = (abort || timer_zero) ? VG_END : VG_DRAW;
         VG_END:    state_d = VG_IDLE;
         VG_HALTED: state_d = restart ? VG_IDLE : VG_HALTED;
         default:   state_d = VG_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they line up with state_q.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= VG_IDLE;
         cmd_ready_q  <= 1'b0;
         go_q         <= 1'b0;
         haltstrobe_q <= 1'b0;
         timer0_q     <= 1'b0;
         beam_on_q    <= 1'b0;
         busy_q       <= 1'b0;
         dv_x_q       <= '0;
         dv_y_q       <= '0;
         beam_en_q    <= 1'b0;
         len_q        <= '0;
      end else begin
         state_q      <= state_d;
         cmd_ready_q  <= (state_d == VG_IDLE);
         busy_q       <= (state_d != VG_IDLE);
         go_q         <= (state_d == VG_DRAW);
         timer0_q     <= (state_d == VG_DRAW);
         beam_on_q    <= (state_d == VG_DRAW) && beam_en_q;
         haltstrobe_q <= (state_d == VG_LOAD);
         if (accept && ((op == VG_OP_LOAD) || (op == VG_OP_DRAW))) begin
            dv_x_q    <= cmd_data[X_HI:X_LO];
            dv_y_q    <= cmd_data[Y_HI:Y_LO];
            beam_en_q <= cmd_data[BEAM_BIT];
            len_q     <= cmd_data[LEN_LO +: LEN_W];
         end
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign dv_x       = dv_x_q;
   assign dv_y       = dv_y_q;
   assign go         = go_q;
   assign haltstrobe = haltstrobe_q;
   assign timer0     = timer0_q;
   assign beam_on    = beam_on_q;
   assign busy       = busy_q;

endmodule
